// File: rtl/hedios_rx_packetizer.sv
// hedios_rx_packetizer: assembles 5-byte UART packets (command + 32-bit data) into a packet FIFO.
// Optional inter-byte timeout is compiled in when HEDIOS_RX_TIMEOUT_EN is defined.
module hedios_rx_packetizer #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_error,
    input  logic                   rx_pop_packet,
    input  logic                   rx_lost_clear,
    output logic [7:0]             rx_command,
    output logic [31:0]            rx_data,
    output logic                   rx_empty,
    output logic                   rx_full,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   rx_lost_data,
    output logic                   rx_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] S_CMD = 3'd0;
    localparam logic [2:0] S_D3  = 3'd1;
    localparam logic [2:0] S_D2  = 3'd2;
    localparam logic [2:0] S_D1  = 3'd3;
    localparam logic [2:0] S_D0  = 3'd4;

    logic [2:0]    state;
    logic [7:0]    cmd_q;
    logic [23:0]   data_q;
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic          accept;
    logic          pkt_done;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic          timeout_hit;

    assign accept   = byte_valid && !byte_error;
    assign pkt_done = accept && (state == S_D0);
    assign pop_ok   = rx_pop_packet && !rx_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
    assign push_ok  = pkt_done && (!rx_full || pop_ok);
    assign drop     = pkt_done && rx_full && !pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_CMD;
            cmd_q  <= '0;
            data_q <= '0;
        end else if (byte_error) begin
            state <= S_CMD;
        end else if (accept) begin
            case (state)
                S_CMD: begin
                    cmd_q <= byte_data;
                    state <= S_D3;
                end
                S_D3: begin
                    data_q <= {data_q[15:0], byte_data};
                    state  <= S_D2;
                end
                S_D2: begin
                    data_q <= {data_q[15:0], byte_data};
                    state  <= S_D1;
                end
                S_D1: begin
                    data_q <= {data_q[15:0], byte_data};
                    state  <= S_D0;
                end
                default: state <= S_CMD;
            endcase
        end else if (timeout_hit) begin
            state <= S_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {cmd_q, data_q, byte_data};
        end
    end

    always_comb begin
        level_next = rx_level;
        if (push_ok && !pop_ok) begin
            level_next = rx_level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = rx_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_level     <= '0;
            rx_empty     <= 1'b1;
            rx_full      <= 1'b0;
            rx_command   <= '0;
            rx_data      <= '0;
            rx_lost_data <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr                <= rd_ptr + AW'(1);
                {rx_command, rx_data} <= mem[rd_ptr];
            end
            rx_level <= level_next;
            rx_empty <= (level_next == '0);
            rx_full  <= (level_next == LW'(DEPTH));
            if (drop) begin
                rx_lost_data <= 1'b1;
            end else if (rx_lost_clear) begin
                rx_lost_data <= 1'b0;
            end
        end
    end

`ifdef HEDIOS_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYCLES-th idle edge; any byte or error strobe that cycle wins.
    assign timeout_hit = (state != S_CMD) && !byte_valid && !byte_error &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= timeout_hit;
            if ((state == S_CMD) || byte_valid || byte_error || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign rx_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_hedios_rx_packetizer.sv
// Scoreboard bench for hedios_rx_packetizer: a queue-based packet model predicts every
// registered output each cycle and the contents of every popped packet.
module tb_hedios_rx_packetizer;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk           = 1'b0;
    logic        rst           = 1'b0;
    logic        byte_valid    = 1'b0;
    logic [7:0]  byte_data     = 8'h00;
    logic        byte_error    = 1'b0;
    logic        rx_pop_packet = 1'b0;
    logic        rx_lost_clear = 1'b0;
    logic [7:0]  rx_command;
    logic [31:0] rx_data;
    logic        rx_empty;
    logic        rx_full;
    logic [3:0]  rx_level;
    logic        rx_lost_data;
    logic        rx_timeout;

    bit [39:0] m_fifo[$];
    bit [7:0]  m_part[$];
    bit [39:0] exp_q[$];
    bit        m_lost;
    bit        m_timeout;
    int        m_idle;
    bit [39:0] m_out;
    bit        m_ready  = 1'b0;
    bit        pop_seen = 1'b0;
    int        errors   = 0;
    int        checks   = 0;

    always #5 clk = ~clk;

    hedios_rx_packetizer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_error   (byte_error),
        .rx_pop_packet(rx_pop_packet),
        .rx_lost_clear(rx_lost_clear),
        .rx_command   (rx_command),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_level     (rx_level),
        .rx_lost_data (rx_lost_data),
        .rx_timeout   (rx_timeout)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the edge just taken did, in terms of byte lists and packet queues.
    function automatic void modelCommit(input bit v, input bit [7:0] d, input bit e,
                                        input bit p, input bit c, input bit r);
        bit        pop_eff;
        bit        was_full;
        bit        done;
        bit [39:0] pkt;
        m_timeout = 1'b0;
        if (r) begin
            m_fifo.delete();
            m_part.delete();
            m_lost  = 1'b0;
            m_idle  = 0;
            m_out   = '0;
            m_ready = 1'b1;
            return;
        end
        pop_eff  = p && (m_fifo.size() > 0);
        was_full = (m_fifo.size() == DEPTH);
        done     = 1'b0;
        pkt      = '0;
        if (e) begin
            m_part.delete();
            m_idle = 0;
        end else if (v) begin
            m_part.push_back(d);
            m_idle = 0;
            if (m_part.size() == 5) begin
                pkt  = {m_part[0], m_part[1], m_part[2], m_part[3], m_part[4]};
                done = 1'b1;
                m_part.delete();
            end
        end else if (m_part.size() > 0) begin
`ifdef HEDIOS_RX_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_part.delete();
                m_idle    = 0;
                m_timeout = 1'b1;
            end
`endif
        end
        if (pop_eff) begin
            m_out = m_fifo.pop_front();
            exp_q.push_back(m_out);
        end
        if (done && (!was_full || pop_eff)) begin
            m_fifo.push_back(pkt);
        end else if (done) begin
            m_lost = 1'b1;
        end
        if (c && !(done && was_full && !pop_eff)) begin
            m_lost = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input bit v, input bit [7:0] d, input bit e,
                                 input bit p, input bit c, input bit r);
        byte_valid    = v;
        byte_data     = d;
        byte_error    = e;
        rx_pop_packet = p;
        rx_lost_clear = c;
        rst           = r;
        @(posedge clk);
        #1;
        modelCommit(v, d, e, p, c, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic popPacket();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sendByte(input bit [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendPacket(input bit [39:0] pkt);
        for (int i = 0; i < 5; i++) sendByte(pkt[39-8*i -: 8]);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_fifo.size() > 0; i++) popPacket();
    endtask

    always @(posedge clk) pop_seen <= rx_pop_packet && !rx_empty && !rst;

    // Monitor: every cycle compare registered outputs, and pop the scoreboard on DUT pops.
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("rx_level", 64'(rx_level), 64'(m_fifo.size()));
            checkOutput("rx_empty", 64'(rx_empty), 64'(m_fifo.size() == 0));
            checkOutput("rx_full", 64'(rx_full), 64'(m_fifo.size() == DEPTH));
            checkOutput("rx_lost_data", 64'(rx_lost_data), 64'(m_lost));
            checkOutput("rx_timeout", 64'(rx_timeout), 64'(m_timeout));
            checkOutput("held_command", 64'(rx_command), 64'(m_out[39:32]));
            if (pop_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop: got %0h_%0h expected no packet", rx_command, rx_data);
                end else begin
                    bit [39:0] e;
                    e = exp_q.pop_front();
                    checkOutput("pop_command", 64'(rx_command), 64'(e[39:32]));
                    checkOutput("pop_data", 64'(rx_data), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        sendPacket(40'h01_DEADBEEF);
        idle(1);
        popPacket();
        idle(2);

        for (int i = 1; i <= 9; i++) sendPacket({8'(i), 32'($urandom)});
        idle(2);
        for (int i = 0; i < 8; i++) popPacket();
        idle(1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        sendByte(8'h02);
        sendByte(8'h11);
        applyStimulus(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        sendPacket(40'h03_00000007);
        popPacket();
        idle(2);

        for (int i = 0; i < DEPTH; i++) sendPacket({8'(8'h40 + i), 32'($urandom)});
        sendByte(8'hC5);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h56);
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        drain();
        idle(1);

        popPacket();
        popPacket();
        sendByte(8'hA1);
        sendByte(8'hA2);
        sendByte(8'hA3);
        sendPacket(40'h10_20304050);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        sendPacket(40'h77_CAFEF00D);
        popPacket();
        idle(2);

        sendByte(8'h82);
        sendByte(8'hAA);
        idle(TO);
        sendPacket(40'h01_00000000);
        idle(2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        sendByte(8'h33);
        idle(TO - 1);
        sendByte(8'h44);
        idle(3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle($urandom_range(TO - 2, TO + 4));
            end else begin
                applyStimulus($urandom_range(0, 2) == 0, 8'($urandom),
                              $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                              $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
            end
        end

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        idle(3);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
